// File: rtl/iccm_loader_pkg.sv
// iccm_loader_pkg: shared FSM encoding and field widths for the ICCM loader.
// ICCM_LOADER_CHECKSUM_EN adds the CHK state.
package iccm_loader_pkg;
    localparam int LenW = 16;
    localparam int ChkW = 8;
    typedef enum logic [2:0] {
        IDLE,
        LEN,
        COLLECT,
        REQ,
        RSP,
        DONE
`ifdef ICCM_LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_e;
endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: minimal TL-UL request/response types used by the ICCM loader.
package tlul_pkg;
    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;
    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;
    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;
    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

// File: rtl/iccm_loader_packer.sv
// iccm_loader_packer: little-endian byte-to-word shift register with a byte counter.
module iccm_loader_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic [1:0]  cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (clr) begin
            word <= '0;
            cnt  <= '0;
        end else if (push) begin
            word <= {data, word[31:8]};
            cnt  <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/iccm_loader.sv
// iccm_loader: streams a length-prefixed byte image into ICCM as TL-UL PutFullData writes.
// Define ICCM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module iccm_loader
    import iccm_loader_pkg::*;
#(
    parameter logic [31:0] BaseAddr   = 32'h0000_0000,
    parameter int unsigned DepthWords = 4096
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       word_cnt_o
);
`ifdef ICCM_LOADER_CHECKSUM_EN
    localparam state_e EndSt = CHK;
`else
    localparam state_e EndSt = DONE;
`endif
    state_e          state_q, state_d;
    logic [LenW-1:0] len_q, cnt_q, len_in;
    logic            err_q, go, rx_fire, len_done, word_done, too_big, last, unused_tl;
    logic [31:0]     word;
    logic [1:0]      byte_cnt;

    assign busy_o     = !(state_q inside {IDLE, DONE});
    assign done_o     = state_q == DONE;
    assign err_o      = err_q;
    assign word_cnt_o = cnt_q;
    assign go         = start_i && !busy_o;
`ifdef ICCM_LOADER_CHECKSUM_EN
    assign rx_ready_o = state_q inside {LEN, COLLECT, CHK};
`else
    assign rx_ready_o = state_q inside {LEN, COLLECT};
`endif
    assign rx_fire    = rx_valid_i && rx_ready_o;
    // The first length byte sits in the packer's top byte when the second arrives.
    assign len_in     = {rx_data_i, word[31:24]};
    assign len_done   = state_q == LEN && rx_fire && byte_cnt == 2'd1;
    assign word_done  = state_q == COLLECT && rx_fire && byte_cnt == 2'd3;
    assign too_big    = 32'(len_in) > DepthWords;
    assign last       = cnt_q + 16'd1 == len_q;
    assign unused_tl  = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                          tl_i.d_sink, tl_i.d_data};

    iccm_loader_packer u_packer (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (go || len_done),
        .push  (rx_fire),
        .data  (rx_data_i),
        .word  (word),
        .cnt   (byte_cnt)
    );

`ifdef ICCM_LOADER_CHECKSUM_EN
    logic [ChkW-1:0] csum_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) csum_q <= '0;
        else if (go) csum_q <= '0;
        else if (state_q == COLLECT && rx_fire) csum_q <= csum_q ^ rx_data_i;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (go) state_d = LEN;
            LEN:        if (len_done) state_d = (len_in == '0 || too_big) ? DONE : COLLECT;
            COLLECT:    if (word_done) state_d = REQ;
            REQ:        if (tl_i.a_ready) state_d = RSP;
            RSP:        if (tl_i.d_valid) state_d = tl_i.d_error ? DONE : last ? EndSt : COLLECT;
`ifdef ICCM_LOADER_CHECKSUM_EN
            CHK:        if (rx_fire) state_d = DONE;
`endif
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (go) begin
                len_q <= '0;
                cnt_q <= '0;
                err_q <= 1'b0;
            end
            if (len_done) begin
                len_q <= len_in;
                err_q <= too_big;
            end
            if (state_q == RSP && tl_i.d_valid) begin
                if (tl_i.d_error) err_q <= 1'b1;
                else cnt_q <= cnt_q + 16'd1;
            end
`ifdef ICCM_LOADER_CHECKSUM_EN
            if (state_q == CHK && rx_fire && rx_data_i != csum_q) err_q <= 1'b1;
`endif
        end
    end

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = state_q == REQ;
        tl_o.a_opcode  = tlul_pkg::PutFullData;
        tl_o.a_size    = 2'd2;
        tl_o.a_mask    = 4'hF;
        tl_o.a_address = BaseAddr + {14'd0, cnt_q, 2'b00};
        tl_o.a_data    = word;
        tl_o.d_ready   = 1'b1;
    end
endmodule

// File: tb/tb_iccm_loader.sv
// tb_iccm_loader: randomized self-checking bench for iccm_loader against a transaction-level model.
// Compile with ICCM_LOADER_CHECKSUM_EN to also exercise the checksum byte.
module tb_iccm_loader;
    import tlul_pkg::*;
    localparam logic [31:0] BASE  = 32'h0002_0000;
    localparam int          DEPTH = 4096;

    logic clk = 0, rst_n = 0, start = 0, rx_valid = 0, rx_ready;
    logic [7:0] rx_data = '0;
    tl_h2d_t tl_h;
    tl_d2h_t tl_d;
    logic busy, done, err;
    logic [15:0] word_cnt;
    logic a_ready = 1, d_valid = 0, d_error = 0, pend = 0, pend_err = 0;
    int err_at = -1, bad_fields = 0, errors = 0, checks = 0;
    bit gaps = 0;
    logic [31:0] cap_addr[$], cap_data[$], words[$];

    always #5 clk = ~clk;

    iccm_loader #(.BaseAddr(BASE), .DepthWords(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rx_ready_o (rx_ready),
        .tl_o       (tl_h),
        .tl_i       (tl_d),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .word_cnt_o (word_cnt)
    );

    always_comb begin
        tl_d         = '0;
        tl_d.a_ready = a_ready;
        tl_d.d_valid = d_valid;
        tl_d.d_error = d_error;
    end

    // Device: records each accepted request and answers one cycle later.
    always @(negedge clk) begin
        if (!rst_n) begin
            d_valid = 0;
            d_error = 0;
            pend    = 0;
        end else begin
            if (d_valid) begin
                d_valid = 0;
                d_error = 0;
            end
            if (pend) begin
                d_valid = 1;
                d_error = pend_err;
                pend    = 0;
            end
            if (tl_h.a_valid && a_ready) begin
                if (tl_h.a_opcode !== PutFullData || tl_h.a_size !== 2'd2 || tl_h.a_mask !== 4'hF ||
                    tl_h.a_source !== 8'd0 || tl_h.d_ready !== 1'b1) bad_fields++;
                pend_err = (err_at == cap_addr.size());
                cap_addr.push_back(tl_h.a_address);
                cap_data.push_back(tl_h.a_data);
                pend = 1;
            end
        end
    end

    task automatic pulse_start();
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_valid = 1;
        rx_data  = b;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: rx_ready=%b want 1 within 200 cycles", rx_ready);
        end
        @(posedge clk);
        #1 rx_valid = 0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %b want 1", tag, done);
        end
    endtask

    // Model: expected traffic and status derived from N, the error slot and checksum choice.
    task automatic run_load(input int n, input bit csum_bad, input string tag);
        bit too_big, derr, exp_err;
        int nsend, exp_cnt;
        logic [7:0] x;
        logic [15:0] len;
        too_big = n > DEPTH;
        derr    = !too_big && n > 0 && err_at >= 0 && err_at < n;
        nsend   = (too_big || n == 0) ? 0 : derr ? err_at + 1 : n;
        exp_cnt = derr ? err_at : too_big ? 0 : n;
        exp_err = too_big || derr;
        x       = '0;
        len     = 16'(n);
        cap_addr.delete();
        cap_data.delete();
        bad_fields = 0;
        pulse_start();
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        for (int i = 0; i < nsend; i++)
            for (int b = 0; b < 4; b++) begin
                send_byte(words[i][8*b +: 8]);
                x ^= words[i][8*b +: 8];
            end
`ifdef ICCM_LOADER_CHECKSUM_EN
        if (!too_big && n > 0 && !derr) begin
            send_byte(x ^ {7'd0, csum_bad});
            exp_err = csum_bad;
        end
`else
        if (csum_bad) x = '0;
`endif
        wait_done(tag);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", tag, busy); end
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL %s err: got %b want %b", tag, err, exp_err); end
        checks++;
        if (word_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL %s word_cnt: got %0d want %0d", tag, word_cnt, exp_cnt); end
        checks++;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL %s rx_ready: got %b want 0", tag, rx_ready); end
        checks++;
        if (cap_addr.size() != nsend) begin errors++; $display("FAIL %s requests: got %0d want %0d", tag, cap_addr.size(), nsend); end
        checks++;
        if (bad_fields != 0) begin errors++; $display("FAIL %s fields: got %0d bad want 0", tag, bad_fields); end
        for (int i = 0; i < nsend && i < cap_addr.size(); i++) begin
            checks++;
            if (cap_addr[i] !== BASE + 32'(4 * i) || cap_data[i] !== words[i]) begin
                errors++;
                $display("FAIL %s req%0d: got %h/%h want %h/%h", tag, i, cap_addr[i], cap_data[i],
                         BASE + 32'(4 * i), words[i]);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, err, rx_ready, tl_h.a_valid} !== 5'b0 || word_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset: got busy%b done%b err%b rdy%b av%b cnt%0d want all 0",
                     busy, done, err, rx_ready, tl_h.a_valid, word_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        words = {32'h1234_5678, 32'hDEAD_BEEF};
        run_load(2, 0, "basic");
    endtask

    task automatic test_latency_and_ignore();
        logic [31:0] w;
        w = $urandom;
        words = {w};
        cap_addr.delete();
        cap_data.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        pulse_start();
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
        checks++;
        if (tl_h.a_valid !== 1'b1) begin errors++; $display("FAIL latency a_valid: got %b want 1", tl_h.a_valid); end
        wait_done("ignore");
        checks++;
        if (word_cnt !== 16'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL ignore status: got cnt%0d err%b want cnt1 err0", word_cnt, err);
        end
        checks++;
        if (cap_data.size() != 1 || cap_data[0] !== w) begin
            errors++;
            $display("FAIL ignore data: got %0d reqs want 1 with %h", cap_data.size(), w);
        end
    endtask

    task automatic test_zero_len();
        cap_addr.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len timing: got done%b busy%b want done1 busy0", done, busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (cap_addr.size() != 0 || word_cnt !== 16'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL zero_len result: got reqs%0d cnt%0d err%b want 0 0 0", cap_addr.size(), word_cnt, err);
        end
    endtask

    task automatic test_bounds();
        run_load(DEPTH + 1, 0, "too_long");
        words = {32'($urandom)};
        err_at = 0;
        run_load(DEPTH, 0, "depth_edge");
        err_at = -1;
    endtask

    task automatic test_derr();
        words = {32'($urandom), 32'($urandom), 32'($urandom)};
        err_at = 1;
        run_load(3, 0, "d_error");
        err_at = -1;
    endtask

    task automatic test_stall_reset();
        logic [31:0] w;
        w = $urandom;
        a_ready = 0;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (tl_h.a_valid !== 1'b1 || tl_h.a_address !== BASE || tl_h.a_data !== w || rx_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall c%0d: got av%b %h/%h rdy%b want av1 %h/%h rdy0", c, tl_h.a_valid,
                         tl_h.a_address, tl_h.a_data, rx_ready, BASE, w);
            end
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (tl_h.a_valid !== 1'b0) begin errors++; $display("FAIL async_reset a_valid: got %b want 0", tl_h.a_valid); end
        checks++;
        if ({busy, done, err, rx_ready} !== 4'b0 || word_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset status: got busy%b done%b err%b rdy%b cnt%0d want 0",
                     busy, done, err, rx_ready, word_cnt);
        end
        @(negedge clk);
        rst_n   = 1;
        a_ready = 1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int n;
        gaps = 1;
        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(1, 5);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run_load(n, 1'($urandom_range(0, 1)), "random");
        end
        err_at = -1;
        gaps   = 0;
    endtask

    task automatic test_back_to_back();
        words = {32'($urandom), 32'($urandom)};
        run_load(2, 0, "b2b_a");
        words = {32'($urandom)};
        run_load(1, 0, "b2b_b");
    endtask

`ifdef ICCM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        words = {32'h0403_0201};
        run_load(1, 0, "csum_ok");
        run_load(1, 1, "csum_bad");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_latency_and_ignore();
        test_zero_len();
        test_bounds();
        test_derr();
        test_stall_reset();
        test_random();
        test_back_to_back();
`ifdef ICCM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/iccm_loader.md
ICCM_LOADER -- requirements
Module: iccm_loader

Interface
REQ-001 SHALL have parameter BaseAddr, default 32'h0000_0000, byte address of ICCM word 0 on the crossbar.
REQ-002 SHALL have parameter DepthWords, default 4096, ICCM capacity in 32-bit words.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start_i  input  1  single-cycle pulse that begins a load.
REQ-006 SHALL have port rx_valid_i  input  1  byte-stream valid.
REQ-007 SHALL have port rx_data_i  input  8  byte-stream data.
REQ-008 SHALL have port rx_ready_o  output  1  byte accepted when rx_valid_i && rx_ready_o.
REQ-009 SHALL have port tl_o  output  tlul_pkg::tl_h2d_t  TL-UL host request to crossbar/ICCM.
REQ-010 SHALL have port tl_i  input  tlul_pkg::tl_d2h_t  TL-UL device response.
REQ-011 SHALL have ports busy_o, done_o, err_o  output  1 each  status.
REQ-012 SHALL have port word_cnt_o  output  16  words acknowledged in current/last load.

Function
REQ-013 SHALL implement FSM IDLE, LEN, COLLECT, REQ, RSP, DONE (plus CHK when REQ-030 applies).
REQ-014 IDLE: start_i -> LEN; clears err_o, done_o, word_cnt_o, byte/word counters.
REQ-015 LEN: accepts 2 bytes, little-endian, forming 16-bit word count N.
REQ-016 After LEN: N==0 -> DONE, no TL traffic; N>DepthWords -> err_o=1, DONE, no TL traffic; else COLLECT.
REQ-017 COLLECT: accepts 4 bytes little-endian (first byte -> bits 7:0), then REQ.
REQ-018 rx_ready_o SHALL be 1 only in LEN and COLLECT (and CHK); 0 in all other states.
REQ-019 REQ: a_valid=1, a_opcode=PutFullData, a_size=2, a_mask=4'hF, a_source=0, a_address=BaseAddr+4*word index, a_data=assembled word; held stable until a_ready, then RSP.
REQ-020 At most one outstanding transaction; d_ready SHALL be tied 1.
REQ-021 RSP: on d_valid with d_error=0, word_cnt_o increments; if word_cnt_o+1==N -> DONE (or CHK), else COLLECT.
REQ-022 RSP: on d_valid with d_error=1 -> err_o=1, DONE; remaining bytes not consumed.
REQ-023 Byte-to-TL latency: a_valid SHALL assert the cycle after the 4th byte handshake.
REQ-024 DONE: done_o=1, busy_o=0; held until next start_i, which re-enters LEN per REQ-014.
REQ-025 busy_o SHALL be 1 in every state except IDLE and DONE.
REQ-026 start_i while busy_o=1 SHALL be ignored.
REQ-027 Word index SHALL be 16 bits, never wraps (bounded by REQ-016).

Reset
REQ-028 On rst_ni low, asynchronously: state IDLE, rx_ready_o=0, a_valid=0, busy_o=0, done_o=0, err_o=0, word_cnt_o=0, internal counters/data 0.
REQ-029 Reset mid-transaction SHALL drop a_valid immediately; partially loaded words are not retried.

Configuration
REQ-030 With ICCM_LOADER_CHECKSUM_EN defined: after last ack, CHK accepts one byte; mismatch with XOR of all data bytes (not length bytes) -> err_o=1; then DONE.
REQ-031 Without ICCM_LOADER_CHECKSUM_EN: no CHK state, no checksum byte consumed, no XOR logic.

Structure
REQ-032 FSM state enum and length/checksum widths SHALL live in shared package iccm_loader_pkg; TL-UL types/opcodes from tlul_pkg.
REQ-033 Byte-to-word assembly (4-byte shift register, byte counter) SHALL be sub-module iccm_loader_packer.

Verification
REQ-034 start, bytes 02 00, 78 56 34 12, EF BE AD DE -> PutFullData 0x12345678 @BaseAddr, 0xDEADBEEF @BaseAddr+4; done_o=1, word_cnt_o=2, err_o=0.
REQ-035 start, bytes 00 00 -> no a_valid ever; done_o=1 one cycle after 2nd byte state update; word_cnt_o=0.
REQ-036 DepthWords=4096, length bytes 01 10 (N=4097) -> err_o=1, done_o=1, no TL request.
REQ-037 N=3, d_error=1 on 2nd ack -> err_o=1, word_cnt_o=1, no 3rd request, rx_ready_o=0.
REQ-038 a_ready held 0 for 5 cycles -> a_address/a_data stable all 5 cycles; rx_ready_o=0; rst_ni low mid-hold -> a_valid=0 same cycle.
REQ-039 Checksum build: N=1, data 01 02 03 04, checksum 04 -> err_o=0; checksum 05 -> err_o=1.
